// File: rtl/maze_tile_renderer.sv
// Writable maze tile map with a two-stage pixel renderer.
// A sweep FSM loads the map from LAYOUT, an eat port removes pellets, and a live
// pellet count is kept for game logic.
module maze_tile_renderer #(
    parameter int unsigned GRID_ROWS = 8,
    parameter int unsigned GRID_COLS = 8,
    parameter int unsigned TILE_PX   = 60,
    parameter int unsigned PELLET_PX = 12,
    parameter logic [GRID_ROWS*GRID_COLS-1:0] LAYOUT = 64'h0078487E42427E00,
    parameter logic [11:0] COLOR_WALL   = 12'h8AF,
    parameter logic [11:0] COLOR_FLOOR  = 12'h000,
    parameter logic [11:0] COLOR_PELLET = 12'hFFF,
    localparam int unsigned N  = GRID_ROWS * GRID_COLS,
    localparam int unsigned RW = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1,
    localparam int unsigned CW = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1,
    localparam int unsigned PW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart,
    input  logic          video_on,
    input  logic [9:0]    p_row,
    input  logic [9:0]    p_col,
    output logic [11:0]   color_data,
    input  logic          eat_valid,
    input  logic [RW-1:0] eat_row,
    input  logic [CW-1:0] eat_col,
    output logic          eat_hit,
    output logic [PW-1:0] pellets_left,
    output logic          all_eaten,
    output logic          ready
);

    localparam int unsigned IW        = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned LastInt   = N - 1;
    localparam int unsigned PelLoInt  = (TILE_PX - PELLET_PX) / 2;
    localparam int unsigned PelHiInt  = (TILE_PX + PELLET_PX) / 2 - 1;

    localparam logic [IW-1:0] LastIdx    = LastInt[IW-1:0];
    localparam logic [IW-1:0] IdxOne     = 1;
    localparam logic [PW-1:0] PelOne     = 1;
    localparam logic [PW-1:0] PelZero    = '0;
    localparam logic [9:0]    TilePx     = TILE_PX[9:0];
    localparam logic [9:0]    PelLo      = PelLoInt[9:0];
    localparam logic [9:0]    PelHi      = PelHiInt[9:0];
    localparam logic [9:0]    GridRows10 = GRID_ROWS[9:0];
    localparam logic [9:0]    GridCols10 = GRID_COLS[9:0];
    localparam logic [15:0]   Cols16     = GRID_COLS[15:0];
    localparam logic [RW:0]   RowLim     = GRID_ROWS[RW:0];
    localparam logic [CW:0]   ColLim     = GRID_COLS[CW:0];

    typedef enum logic [0:0] {StInit, StRun} state_e;
    typedef enum logic [1:0] {
        TileWall   = 2'd0,
        TileFloor  = 2'd1,
        TilePellet = 2'd2
    } tile_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [PW-1:0] pellets_q, pellets_d;
    logic          eat_hit_q, eat_hit_d;
    logic          all_eaten_q, all_eaten_d;
    tile_e         tile_q [N];
    tile_e         tile_d [N];

    // Pixel pipeline registers
    logic [9:0]    orow_q, orow_d, ocol_q, ocol_d;
    logic [IW-1:0] tidx_q, tidx_d;
    logic          in_grid_q, in_grid_d;
    logic [11:0]   color_q, color_d;

    logic [9:0]    tr, tc;
    logic [15:0]   pix_lin, eat_lin;
    logic [IW-1:0] eat_idx;
    logic          eat_ok;
    tile_e         rd_tile;

    // Sweep FSM, eat handling and pellet bookkeeping
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pellets_d = pellets_q;
        eat_hit_d = 1'b0;
        tile_d    = tile_q;
        eat_lin   = 16'(eat_row) * Cols16 + 16'(eat_col);
        eat_idx   = eat_lin[IW-1:0];
        eat_ok    = eat_valid && ({1'b0, eat_row} < RowLim) && ({1'b0, eat_col} < ColLim);

        unique case (state_q)
            StInit: begin
                if (restart) begin
                    idx_d     = '0;
                    pellets_d = '0;
                end else begin
                    if (LAYOUT[LastIdx - idx_q]) begin
                        tile_d[idx_q] = TilePellet;
                        pellets_d     = pellets_q + PelOne;
                    end else begin
                        tile_d[idx_q] = TileWall;
                    end
                    if (idx_q == LastIdx) begin
                        state_d = StRun;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IdxOne;
                    end
                end
            end
            StRun: begin
                if (restart) begin
                    // Restart wins over a concurrent eat request.
                    state_d   = StInit;
                    idx_d     = '0;
                    pellets_d = '0;
                end else if (eat_ok && tile_q[eat_idx] == TilePellet && pellets_q != PelZero) begin
                    tile_d[eat_idx] = TileFloor;
                    pellets_d       = pellets_q - PelOne;
                    eat_hit_d       = 1'b1;
                end
            end
            default: state_d = StInit;
        endcase

        all_eaten_d = (state_d == StRun) && (pellets_d == PelZero);
    end

    // Pixel stage 1 (tile coordinates) and stage 2 (colour select)
    always_comb begin
        tr        = p_row / TilePx;
        tc        = p_col / TilePx;
        orow_d    = p_row % TilePx;
        ocol_d    = p_col % TilePx;
        pix_lin   = 16'(tr) * Cols16 + 16'(tc);
        tidx_d    = pix_lin[IW-1:0];
        in_grid_d = video_on && (tr < GridRows10) && (tc < GridCols10);

        // Reads the pre-eat tile value when an eat lands on the same tile this cycle.
        rd_tile = in_grid_q ? tile_q[tidx_q] : TileWall;
        color_d = COLOR_FLOOR;
        if (in_grid_q && state_q == StRun) begin
            if (rd_tile == TileWall) begin
                color_d = COLOR_WALL;
            end else if (rd_tile == TilePellet && orow_q >= PelLo && orow_q <= PelHi &&
                         ocol_q >= PelLo && ocol_q <= PelHi) begin
                color_d = COLOR_PELLET;
            end
        end
    end

    // State, tile map and pipeline registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StInit;
            idx_q       <= '0;
            pellets_q   <= '0;
            eat_hit_q   <= 1'b0;
            all_eaten_q <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                tile_q[i] <= TileWall;
            end
            orow_q      <= '0;
            ocol_q      <= '0;
            tidx_q      <= '0;
            in_grid_q   <= 1'b0;
            color_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pellets_q   <= pellets_d;
            eat_hit_q   <= eat_hit_d;
            all_eaten_q <= all_eaten_d;
            tile_q      <= tile_d;
            orow_q      <= orow_d;
            ocol_q      <= ocol_d;
            tidx_q      <= tidx_d;
            in_grid_q   <= in_grid_d;
            color_q     <= color_d;
        end
    end

    assign color_data   = color_q;
    assign eat_hit      = eat_hit_q;
    assign pellets_left = pellets_q;
    assign all_eaten    = all_eaten_q;
    assign ready        = (state_q == StRun);

endmodule

// File: tb/tb_maze_tile_renderer.sv
// Self-checking bench for maze_tile_renderer: directed steps plus randomized pixels
// and eats checked against a tile-map reference model.
module tb_maze_tile_renderer;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int TPX  = 60;
    localparam int PPX  = 12;
    localparam logic [63:0] LAYOUT_C = 64'h0078487E42427E00;

    logic        clk = 1'b0;
    logic        reset, restart, video_on;
    logic [9:0]  p_row, p_col;
    logic [11:0] color_data;
    logic        eat_valid;
    logic [2:0]  eat_row, eat_col;
    logic        eat_hit;
    logic [6:0]  pellets_left;
    logic        all_eaten, ready;

    always #5 clk = ~clk;

    maze_tile_renderer #(
        .GRID_ROWS(8), .GRID_COLS(8), .TILE_PX(60), .PELLET_PX(12),
        .LAYOUT(64'h0078487E42427E00),
        .COLOR_WALL(12'h8AF), .COLOR_FLOOR(12'h000), .COLOR_PELLET(12'hFFF)
    ) dut (
        .clk(clk), .reset(reset), .restart(restart), .video_on(video_on),
        .p_row(p_row), .p_col(p_col), .color_data(color_data),
        .eat_valid(eat_valid), .eat_row(eat_row), .eat_col(eat_col),
        .eat_hit(eat_hit), .pellets_left(pellets_left),
        .all_eaten(all_eaten), .ready(ready)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int mt [64];      // 0 wall, 1 floor, 2 pellet
    int m_pel = 0;
    bit m_ready = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_corr(int t);
        logic [63:0] l;
        l = LAYOUT_C;
        return l[63 - t];
    endfunction

    function automatic logic [11:0] exp_color(int r, int c, bit von);
        int tr, tc, orow, ocol, lo, hi;
        tr = r / TPX; tc = c / TPX; orow = r % TPX; ocol = c % TPX;
        lo = (TPX - PPX) / 2; hi = (TPX + PPX) / 2 - 1;
        if (!von || !m_ready || tr >= ROWS || tc >= COLS) return 12'h000;
        if (mt[tr * COLS + tc] == 0) return 12'h8AF;
        if (mt[tr * COLS + tc] == 2 && orow >= lo && orow <= hi && ocol >= lo && ocol <= hi)
            return 12'hFFF;
        return 12'h000;
    endfunction

    task automatic model_load();
        m_pel = 0;
        for (int t = 0; t < 64; t++) begin
            mt[t] = is_corr(t) ? 2 : 0;
            if (is_corr(t)) m_pel++;
        end
        m_ready = 1'b1;
    endtask

    task automatic pix(input int r, input int c, input bit von, input logic [11:0] exp,
                       input string tag);
        p_row = 10'(r); p_col = 10'(c); video_on = von;
        tick();
        tick();
        chk(tag, 32'(color_data), 32'(exp));
    endtask

    // One-cycle eat; leaves eat_valid high so consecutive calls are back-to-back.
    task automatic eat(input int r, input int c, output bit hit);
        bit exp_hit;
        eat_valid = 1'b1; eat_row = 3'(r); eat_col = 3'(c);
        exp_hit = m_ready && mt[r * COLS + c] == 2;
        if (exp_hit) begin
            mt[r * COLS + c] = 1;
            m_pel--;
        end
        tick();
        hit = eat_hit;
        chk("eat_hit", 32'(eat_hit), 32'(exp_hit));
        chk("eat_pellets_left", 32'(pellets_left), 32'(m_pel));
        chk("eat_all_eaten", 32'(all_eaten), 32'(m_ready && m_pel == 0));
    endtask

    initial begin
        bit h;
        int hits, exp_hits, r, c, pre;
        reset = 1'b1; restart = 1'b0; video_on = 1'b1; p_row = '0; p_col = '0;
        eat_valid = 1'b0; eat_row = '0; eat_col = '0;
        for (int t = 0; t < 64; t++) mt[t] = 0;

        // 1: reset values, sweep length, pellet count
        tick(); tick();
        chk("rst_color", 32'(color_data), 0);
        chk("rst_eat_hit", 32'(eat_hit), 0);
        chk("rst_pellets", 32'(pellets_left), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_all_eaten", 32'(all_eaten), 0);
        reset = 1'b0;
        for (int i = 1; i < 64; i++) begin
            tick();
            chk("init_ready_low", 32'(ready), 0);
        end
        tick();
        model_load();
        chk("ready_at_64", 32'(ready), 1);
        chk("init_pellets", 32'(pellets_left), 22);
        chk("init_all_eaten", 32'(all_eaten), 0);

        // 2: directed pixels
        pix(10, 10, 1'b1, 12'h8AF, "pix_wall");
        pix(90, 90, 1'b1, 12'hFFF, "pix_pellet");
        pix(65, 65, 1'b1, 12'h000, "pix_floor_edge");
        pix(10, 500, 1'b1, 12'h000, "pix_out_of_grid");
        pix(90, 90, 1'b0, 12'h000, "pix_video_off");

        // 3: directed eats
        eat(1, 1, h);
        eat_valid = 1'b0;
        chk("eat11_pellets", 32'(pellets_left), 21);
        pix(90, 90, 1'b1, 12'h000, "pix_after_eat");
        eat(1, 1, h);
        eat(0, 0, h);
        eat_valid = 1'b0;
        chk("eat_repeat_pellets", 32'(pellets_left), 21);

        // Randomized eats and pixels against the model
        for (int i = 0; i < 15; i++) begin
            eat($urandom_range(0, 7), $urandom_range(0, 7), h);
        end
        eat_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                r = $urandom_range(0, 9) * TPX + $urandom_range(20, 39);
                c = $urandom_range(0, 9) * TPX + $urandom_range(20, 39);
            end else begin
                r = $urandom_range(0, 599);
                c = $urandom_range(0, 799);
            end
            h = ($urandom_range(0, 3) != 0);
            pix(r, c, h, exp_color(r, c, h), "pix_random");
        end

        // 4: eat every corridor tile back-to-back
        hits = 0;
        exp_hits = m_pel;
        for (int t = 0; t < 64; t++) begin
            if (is_corr(t)) begin
                eat(t / COLS, t % COLS, h);
                if (h) hits++;
            end
        end
        eat_valid = 1'b0;
        chk("sweep_hits", 32'(hits), 32'(exp_hits));
        chk("sweep_pellets_zero", 32'(pellets_left), 0);
        chk("sweep_all_eaten", 32'(all_eaten), 1);

        // 5: restart, eats ignored during the sweep
        restart = 1'b1;
        tick();
        restart = 1'b0;
        m_ready = 1'b0;
        chk("restart_ready_low", 32'(ready), 0);
        chk("restart_pellets", 32'(pellets_left), 0);
        for (int i = 1; i < 64; i++) begin
            eat_valid = 1'b1;
            eat_row = 3'($urandom_range(0, 7));
            eat_col = 3'($urandom_range(0, 7));
            tick();
            chk("reinit_ready_low", 32'(ready), 0);
            chk("reinit_eat_ignored", 32'(eat_hit), 0);
        end
        eat_valid = 1'b0;
        tick();
        model_load();
        chk("reinit_ready", 32'(ready), 1);
        chk("reinit_pellets", 32'(pellets_left), 22);
        pix(90, 90, 1'b1, 12'hFFF, "reinit_pix_pellet");

        // 6: async reset mid-sweep together with eat and restart
        restart = 1'b1;
        tick();
        restart = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        pre = 0;
        for (int t = 0; t < 30; t++) if (is_corr(t)) pre++;
        chk("midsweep_pellets", 32'(pellets_left), 32'(pre));
        eat_valid = 1'b1; eat_row = 3'd1; eat_col = 3'd1; restart = 1'b1; reset = 1'b1;
        #1;
        chk("async_color", 32'(color_data), 0);
        chk("async_eat_hit", 32'(eat_hit), 0);
        chk("async_pellets", 32'(pellets_left), 0);
        chk("async_ready", 32'(ready), 0);
        chk("async_all_eaten", 32'(all_eaten), 0);
        tick();
        reset = 1'b0; restart = 1'b0; eat_valid = 1'b0;
        for (int i = 1; i < 64; i++) tick();
        chk("post_reset_ready_low", 32'(ready), 0);
        tick();
        model_load();
        chk("post_reset_ready", 32'(ready), 1);
        chk("post_reset_pellets", 32'(pellets_left), 22);
        pix(90, 90, 1'b1, 12'hFFF, "post_reset_pix");
        eat(1, 1, h);
        eat_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
